id_ex_stage: RTL and testbench

// - ID->EX pipeline register feeding the 3-bit-control ALU directly downstream.
// - Decodes opcode/funct into ALU ctrl and memory/writeback/branch controls.
// - Selects ALU operands: register, sign-extended immediate, or shamt.
// - Holds one instruction behind a valid/ready handshake, with flush for branch redirect.

---
 rtl/mips_pkg.sv | 61 ++++++
 rtl/id_alu_decode.sv | 66 ++++++
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 tb/tb_id_ex_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the ID->EX slice: opcode/funct values the decoder
// recognises, the 3-bit ALU control encodings, the operand-select enums and
// the bundle of decoded control bits passed from the decoder to the stage.
package mips_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_LW  = 3'b001,
        ALU_SW  = 3'b010,
        ALU_AND = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_BEQ = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef enum logic {
        IN1_RS = 1'b0,
        IN1_RT = 1'b1
    } in1_sel_e;

    typedef enum logic [1:0] {
        IN2_RT    = 2'b00,
        IN2_IMM   = 2'b01,
        IN2_SHAMT = 2'b10
    } in2_sel_e;

    typedef enum logic {
        DST_RD = 1'b0,
        DST_RT = 1'b1
    } dst_sel_e;

    typedef struct packed {
        alu_ctrl_e alu_ctrl;
        in1_sel_e  in1_sel;
        in2_sel_e  in2_sel;
        dst_sel_e  dst_sel;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      branch;
        logic      illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/id_alu_decode.sv
// Combinational instruction decoder.
// Ports:
//   opcode_i  instr[31:26]
//   funct_i   instr[5:0], only meaningful for R-type
//   ctrl_o    ALU control, operand/destination selects, write-enables, illegal flag
// An unrecognised opcode/funct yields all enables low plus illegal=1.
module id_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output dec_ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.dst_sel   = DST_RD;
                case (funct_i)
                    FN_ADD: ctrl_o.alu_ctrl = ALU_ADD;
                    FN_AND: ctrl_o.alu_ctrl = ALU_AND;
                    FN_NOR: ctrl_o.alu_ctrl = ALU_NOR;
                    FN_SLT: ctrl_o.alu_ctrl = ALU_SLT;
                    FN_SLL: begin
                        // Shifts take the value from rt and the amount from shamt.
                        ctrl_o.alu_ctrl = ALU_SLL;
                        ctrl_o.in1_sel  = IN1_RT;
                        ctrl_o.in2_sel  = IN2_SHAMT;
                    end
                    default: begin
                        ctrl_o.reg_write = 1'b0;
                        ctrl_o.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                ctrl_o.alu_ctrl  = ALU_ADD;
                ctrl_o.in2_sel   = IN2_IMM;
                ctrl_o.dst_sel   = DST_RT;
                ctrl_o.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl_o.alu_ctrl  = ALU_LW;
                ctrl_o.in2_sel   = IN2_IMM;
                ctrl_o.dst_sel   = DST_RT;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.mem_read  = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alu_ctrl  = ALU_SW;
                ctrl_o.in2_sel   = IN2_IMM;
                ctrl_o.dst_sel   = DST_RT;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.alu_ctrl = ALU_BEQ;
                ctrl_o.dst_sel  = DST_RT;
                ctrl_o.branch   = 1'b1;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with decode, operand selection and a valid/ready
// handshake. Holds one instruction; flush kills both the held and the
// incoming instruction.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     decode-side handshake
//   out_valid/out_ready   EX/MEM-side handshake
//   flush                 branch-redirect kill
//   opcode..pc_plus4      instruction fields and register-file data
//   alu_ctrl, alu_in1/2   ALU command and operands
//   store_data, dst_reg   sw data and write-back register
//   reg_write, mem_read, mem_write, branch, br_target   downstream controls
//   illegal               one-cycle pulse on accepting an unsupported instruction
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter bit ILLEGAL_NOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [4:0]      shamt,
    input  logic [15:0]     imm16,
    input  logic [4:0]      rt_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic [XLEN-1:0] pc_plus4,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      dst_reg,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic [XLEN-1:0] br_target,
    output logic            illegal
);

    dec_ctrl_t       dec;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] in1_d;
    logic [XLEN-1:0] in2_d;
    logic [4:0]      dst_d;
    logic            capture;

    logic            valid_q;
    logic [2:0]      alu_ctrl_q;
    logic [XLEN-1:0] in1_q;
    logic [XLEN-1:0] in2_q;
    logic [XLEN-1:0] store_q;
    logic [4:0]      dst_q;
    logic            reg_write_q;
    logic            mem_read_q;
    logic            mem_write_q;
    logic            branch_q;
    logic [XLEN-1:0] br_target_q;
    logic            illegal_q;

    id_alu_decode u_decode (
        .opcode_i (opcode),
        .funct_i  (funct),
        .ctrl_o   (dec)
    );

    assign imm_sext = {{(XLEN-16){imm16[15]}}, imm16};
    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        in1_d = (dec.in1_sel == IN1_RT) ? rt_data : rs_data;
        case (dec.in2_sel)
            IN2_IMM:   in2_d = imm_sext;
            IN2_SHAMT: in2_d = {{(XLEN-5){1'b0}}, shamt};
            default:   in2_d = rt_data;
        endcase
        dst_d = (dec.dst_sel == DST_RT) ? rt_addr : rd_addr;
    end

    // Flush beats capture and stall. Enables are cleared whenever the slot
    // empties so a stale instruction can never write. An illegal instruction
    // either becomes a bubble or enters with its (already zero) enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            alu_ctrl_q  <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            store_q     <= '0;
            dst_q       <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            br_target_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            if (flush) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                branch_q    <= 1'b0;
            end else if (capture) begin
                valid_q     <= !(dec.illegal && ILLEGAL_NOP);
                illegal_q   <= dec.illegal;
                alu_ctrl_q  <= dec.alu_ctrl;
                in1_q       <= in1_d;
                in2_q       <= in2_d;
                store_q     <= rt_data;
                dst_q       <= dst_d;
                // Writing $zero is a no-op, which also makes sll $0 a NOP.
                reg_write_q <= dec.reg_write && (dst_d != 5'd0);
                mem_read_q  <= dec.mem_read;
                mem_write_q <= dec.mem_write;
                branch_q    <= dec.branch;
                br_target_q <= pc_plus4 + (imm_sext << 2);
            end else if (out_ready) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                branch_q    <= 1'b0;
            end
        end
    end

    assign out_valid  = valid_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign store_data = store_q;
    assign dst_reg    = dst_q;
    assign reg_write  = reg_write_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign branch     = branch_q;
    assign br_target  = br_target_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver issues directed and random
// instructions, a reference model predicts each accepted instruction and
// queues it, and a monitor compares the queue head whenever EX shows it.
module tb_id_ex_stage;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] store;
        logic [31:0] target;
        logic [4:0]  dst;
        logic        dstKnown;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        isIllegal;
    } expect_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc_plus4;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] store_data;
    logic [4:0]  dst_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [31:0] br_target;
    logic        illegal;

    int          checks = 0;
    int          errors = 0;
    expect_t     expQ[$];
    logic        modelValid = 1'b0;
    logic        expIllegal = 1'b0;
    logic        flushedLast = 1'b0;
    logic        monitorOn = 1'b0;

    id_ex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .opcode     (opcode),
        .funct      (funct),
        .shamt      (shamt),
        .imm16      (imm16),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .pc_plus4   (pc_plus4),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_ctrl   (alu_ctrl),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .store_data (store_data),
        .dst_reg    (dst_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .br_target  (br_target),
        .illegal    (illegal)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference: each supported instruction lists what EX
    // should see; anything else is illegal and becomes a bubble.
    function automatic expect_t refModel(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [4:0] sh, input logic [15:0] imm,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [31:0] rsD, input logic [31:0] rtD,
                                         input logic [31:0] pc);
        expect_t e;
        logic [31:0] sext;
        sext = {{16{imm[15]}}, imm};
        e = '0;
        e.store  = rtD;
        e.target = pc + sext * 32'd4;
        e.in1    = rsD;
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h24 || fn == 6'h27 || fn == 6'h2A)) begin
            e.ctrl = (fn == 6'h20) ? 3'd0 : (fn == 6'h24) ? 3'd3 : (fn == 6'h27) ? 3'd4 : 3'd7;
            e.in2 = rtD; e.dst = rd; e.dstKnown = 1'b1; e.rw = 1'b1;
        end else if (op == 6'h00 && fn == 6'h00) begin
            e.ctrl = 3'd5; e.in1 = rtD; e.in2 = 32'(sh); e.dst = rd; e.dstKnown = 1'b1; e.rw = 1'b1;
        end else if (op == 6'h08) begin
            e.ctrl = 3'd0; e.in2 = sext; e.dst = rt; e.dstKnown = 1'b1; e.rw = 1'b1;
        end else if (op == 6'h23) begin
            e.ctrl = 3'd1; e.in2 = sext; e.dst = rt; e.dstKnown = 1'b1; e.rw = 1'b1; e.mr = 1'b1;
        end else if (op == 6'h2B) begin
            e.ctrl = 3'd2; e.in2 = sext; e.mw = 1'b1;
        end else if (op == 6'h04) begin
            e.ctrl = 3'd6; e.in2 = rtD; e.br = 1'b1;
        end else begin
            e.isIllegal = 1'b1;
        end
        if (e.dstKnown && e.dst == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    // Drives one cycle of inputs, then advances the model at the edge.
    task automatic applyStimulus(input logic v, input logic fl, input logic ordy,
                                 input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                 input logic [15:0] imm, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] rsD, input logic [31:0] rtD, input logic [31:0] pc);
        expect_t e;
        logic    cap;
        in_valid = v; flush = fl; out_ready = ordy;
        opcode = op; funct = fn; shamt = sh; imm16 = imm;
        rt_addr = rt; rd_addr = rd; rs_data = rsD; rt_data = rtD; pc_plus4 = pc;
        @(posedge clk);
        cap = v && (!modelValid || ordy) && !fl;
        expIllegal = 1'b0;
        flushedLast = fl;
        if (fl) begin
            expQ.delete();
            modelValid = 1'b0;
        end else begin
            if (modelValid && ordy) modelValid = 1'b0;
            if (cap) begin
                e = refModel(op, fn, sh, imm, rt, rd, rsD, rtD, pc);
                expIllegal = e.isIllegal;
                if (!e.isIllegal) begin
                    expQ.push_back(e);
                    modelValid = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic checkResetState();
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
        checkOutput("rst alu_in1", alu_in1, 32'd0);
        checkOutput("rst alu_in2", alu_in2, 32'd0);
        checkOutput("rst store_data", store_data, 32'd0);
        checkOutput("rst dst_reg", 32'(dst_reg), 32'd0);
        checkOutput("rst enables", {28'd0, reg_write, mem_read, mem_write, branch}, 32'd0);
        checkOutput("rst br_target", br_target, 32'd0);
        checkOutput("rst illegal", 32'(illegal), 32'd0);
    endtask

    // Monitor: mid-cycle, compare handshake and whatever EX is presenting;
    // the head leaves the queue once EX/MEM accepts it.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("in_ready", 32'(in_ready), 32'(!modelValid || out_ready));
            checkOutput("out_valid", 32'(out_valid), 32'(modelValid));
            checkOutput("illegal", 32'(illegal), 32'(expIllegal));
            if (flushedLast)
                checkOutput("flush enables", {28'd0, reg_write, mem_read, mem_write, branch}, 32'd0);
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected output", 32'(out_valid), 32'd0);
                end else begin
                    checkOutput("alu_ctrl", 32'(alu_ctrl), 32'(expQ[0].ctrl));
                    checkOutput("alu_in1", alu_in1, expQ[0].in1);
                    checkOutput("alu_in2", alu_in2, expQ[0].in2);
                    checkOutput("store_data", store_data, expQ[0].store);
                    checkOutput("br_target", br_target, expQ[0].target);
                    checkOutput("reg_write", 32'(reg_write), 32'(expQ[0].rw));
                    checkOutput("mem_read", 32'(mem_read), 32'(expQ[0].mr));
                    checkOutput("mem_write", 32'(mem_write), 32'(expQ[0].mw));
                    checkOutput("branch", 32'(branch), 32'(expQ[0].br));
                    if (expQ[0].dstKnown) checkOutput("dst_reg", 32'(dst_reg), 32'(expQ[0].dst));
                    if (out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        logic [5:0] opList [6];
        logic [5:0] fnList [6];
        logic [5:0] op;
        logic [5:0] fn;
        opList = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h00};
        fnList = '{6'h20, 6'h24, 6'h27, 6'h2A, 6'h00, 6'h20};
        in_valid = 0; flush = 0; out_ready = 0; opcode = 0; funct = 0; shamt = 0;
        imm16 = 0; rt_addr = 0; rd_addr = 0; rs_data = 0; rt_data = 0; pc_plus4 = 0;
        rst_n = 1'b0;
        #3;
        checkResetState();
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        monitorOn = 1'b1;

        // Directed: add, lw, beq, sll, then an illegal opcode.
        applyStimulus(1, 0, 1, 6'h00, 6'h20, 5'd0, 16'h0000, 5'd2, 5'd9, 32'd5, 32'd7, 32'h10);
        applyStimulus(1, 0, 1, 6'h23, 6'h00, 5'd0, 16'hFFFC, 5'd4, 5'd0, 32'd100, 32'd1, 32'h14);
        applyStimulus(1, 0, 1, 6'h04, 6'h00, 5'd0, 16'h0003, 5'd5, 5'd0, 32'd1, 32'd1, 32'h40);
        applyStimulus(1, 0, 1, 6'h00, 6'h00, 5'd31, 16'h07C0, 5'd1, 5'd8, 32'd0, 32'd1, 32'h44);
        applyStimulus(1, 0, 1, 6'h3F, 6'h00, 5'd0, 16'h0000, 5'd3, 5'd3, 32'd2, 32'd3, 32'h48);
        // sll with rd=0 is a NOP.
        applyStimulus(1, 0, 1, 6'h00, 6'h00, 5'd4, 16'h0100, 5'd6, 5'd0, 32'd0, 32'd9, 32'h4C);
        // Stall three cycles with a new instruction waiting, then release.
        applyStimulus(1, 0, 1, 6'h08, 6'h00, 5'd0, 16'h8000, 5'd7, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h50);
        repeat (3) applyStimulus(1, 0, 0, 6'h00, 6'h24, 5'd0, 16'h0000, 5'd2, 5'd3, 32'hF0F0, 32'h0FF0, 32'h54);
        applyStimulus(1, 0, 1, 6'h00, 6'h24, 5'd0, 16'h0000, 5'd2, 5'd3, 32'hF0F0, 32'h0FF0, 32'h54);
        // Flush with an incoming instruction, including while stalled.
        applyStimulus(1, 0, 0, 6'h2B, 6'h00, 5'd0, 16'h0010, 5'd8, 5'd0, 32'd64, 32'hABCD, 32'h58);
        applyStimulus(1, 1, 0, 6'h00, 6'h2A, 5'd0, 16'h0000, 5'd2, 5'd3, 32'd1, 32'd2, 32'h5C);
        applyStimulus(0, 0, 1, 6'h00, 6'h20, 5'd0, 16'h0000, 5'd2, 5'd3, 32'd1, 32'd2, 32'h60);

        // Randomised traffic with mostly-legal instructions.
        for (int i = 0; i < 400; i++) begin
            op = opList[$urandom_range(0, 5)];
            fn = fnList[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                          $urandom_range(0, 9) < 7, op, fn, 5'($urandom), 16'($urandom),
                          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                          $urandom, $urandom, $urandom);
        end

        // Reset pulse in the middle of a stall clears everything at once.
        applyStimulus(1, 0, 1, 6'h00, 6'h27, 5'd0, 16'h0000, 5'd2, 5'd3, 32'h1234, 32'h5678, 32'h70);
        applyStimulus(1, 0, 0, 6'h00, 6'h20, 5'd0, 16'h0000, 5'd2, 5'd3, 32'h1, 32'h2, 32'h74);
        monitorOn = 1'b0;
        checkOutput("stall held out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkResetState();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
